stbus_deframer: RTL and testbench
=================================

STBUS_DEFRAMER -- requirements
Module: stbus_deframer

Interface
REQ-001 Parameter SLOT_MASK, default 32'hFFFF_FFFF; bit n=1 enables delivery of timeslot n.
REQ-002 Parameter FIFO_DEPTH, default 4; output FIFO entries, power of two, at least 2.
REQ-003 Parameter SYNC_STAGES, default 2; synchroniser depth for c4, f0 and data_from_dt.
REQ-004 clk50  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_in_rg  in  1  synchronous, active-low reset.
REQ-006 c4  in  1  ST-BUS bit clock; 2 c4 periods per data bit; asynchronous to clk50.
REQ-007 f0  in  1  frame pulse, active-low, asynchronous.
REQ-008 data_from_dt  in  1  serial ST-BUS data, MSB first; 32 slots of 8 bits per frame.
REQ-009 out_data  out  8  received slot byte.
REQ-010 out_slot  out  5  timeslot number of out_data.
REQ-011 out_valid  out  1  FIFO head valid.
REQ-012 out_ready  in  1  consumer accepts the head; a pop occurs when out_valid and out_ready are both 1.
REQ-013 in_sync  out  1  high while in state SYNC.
REQ-014 frame_err  out  1  sticky; frame pulse missing or misplaced.
REQ-015 overflow  out  1  sticky; byte dropped because the FIFO was full.
REQ-016 err_clr  in  1  single-cycle clear of frame_err and overflow.
REQ-017 cpu_int  out  1  level interrupt; frame complete.
REQ-018 int_ack  in  1  single-cycle clear of cpu_int.

Function
REQ-019 c4, f0 and data_from_dt SHALL each pass through SYNC_STAGES flops; a c4 fall event is prev_sync=1 and cur_sync=0.
REQ-020 All per-event decisions SHALL use f0_s and data_s from the same synchroniser stage as cur_sync.
REQ-021 A 9-bit counter cnt SHALL advance once per c4 fall event, wrapping 511->0.
REQ-022 State HUNT: cnt and data are ignored; a fall event with f0_s=0 SHALL load cnt=1 and enter SYNC.
REQ-023 State SYNC: a fall event with f0_s=0 at pre-update cnt=0 is a good frame; at cnt!=0 it SHALL set frame_err and load cnt=1, remaining in SYNC.
REQ-024 State SYNC: a fall event at pre-update cnt=0 with f0_s=1 SHALL set frame_err and enter HUNT.
REQ-025 In SYNC, a fall event with pre-update cnt[0]=1 SHALL shift data_s into an 8-bit shift register, MSB first; the bit index is cnt[8:1].
REQ-026 A sample with cnt[3:1]=7 completes slot cnt[8:4]; if SLOT_MASK[slot]=1, {slot, byte} SHALL be pushed on the next clk50.
REQ-027 out_valid SHALL rise one clk50 after the push into an empty FIFO; head outputs are registered; FIFO ordering is first-in first-out.
REQ-028 A push while the FIFO is full SHALL drop the byte and set overflow. A simultaneous push and pop on a full FIFO SHALL succeed.
REQ-029 Completion of slot 31 in SYNC SHALL set cpu_int, regardless of SLOT_MASK.
REQ-030 If a set condition and its clear (int_ack or err_clr) occur in the same cycle, the set SHALL win.
REQ-031 Entering HUNT SHALL discard any partial byte; FIFO contents SHALL be kept.

Reset
REQ-032 While reset_in_rg=0 at a clk50 edge, the following SHALL hold: state=HUNT, cnt=0, shift register=0, FIFO empty.
REQ-033 While reset_in_rg=0, all outputs SHALL be 0.
REQ-034 While reset_in_rg=0, the c4 synchroniser SHALL be 0, and the f0 synchroniser SHALL be 1.
REQ-035 Reset mid-frame SHALL abort all activity; after release, the block SHALL await the next f0.

Structure
REQ-036 Package stbus_pkg SHALL hold SLOTS=32, BITS_PER_SLOT=8, C4_PER_FRAME=512, the state enum {HUNT, SYNC} and the FIFO entry type {slot[4:0], data[7:0]}.
REQ-037 The FIFO SHALL be a separate sub-module stbus_fifo: synchronous, registered head, with full and empty flags.

Verification
REQ-038 Scenario 1 (normal frame): slot n carries byte 8'hA0+n, out_ready=1 -> 32 entries in slot order 0..31 with matching data; cpu_int=1 after slot 31; in_sync=1.
REQ-039 Scenario 2 (slot masking): SLOT_MASK=32'h0000_0005 -> only slots 0 and 2 are delivered; cpu_int is still set.
REQ-040 Scenario 3 (back-pressure): out_ready=0 for a whole frame with FIFO_DEPTH=4 -> slots 0..3 are held and overflow=1. After err_clr and out_ready=1, the FIFO pops 0,1,2,3.
REQ-041 Scenario 4 (early frame pulse): f0 low at cnt=200 -> frame_err=1, in_sync stays 1, and the next slot 0 is realigned. A missing f0 -> frame_err=1, in_sync=0.
REQ-042 Scenario 5 (collisions): int_ack coincident with slot 31 completion -> cpu_int stays 1. err_clr coincident with a new overflow -> overflow stays 1.
REQ-043 Scenario 6 (reset mid-frame): reset_in_rg low at slot 10 -> all outputs are 0 next cycle; after release, bytes resume only after the next f0.

Source files
------------

// File: rtl/stbus_pkg.sv
// Shared constants and types for the ST-BUS receive deframer.
// Frame geometry, receiver state and the FIFO entry layout.
package stbus_pkg;
  localparam int SLOTS         = 32;
  localparam int BITS_PER_SLOT = 8;
  localparam int C4_PER_FRAME  = 512;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    SYNC = 1'b1
  } state_t;

  typedef struct packed {
    logic [4:0] slot;
    logic [7:0] data;
  } fifo_entry_t;
endpackage

// File: rtl/stbus_fifo.sv
// Shift-register FIFO: the head always sits in r_mem[0], so head outputs come straight from flops.
// Handshake: an entry leaves when i_pop is high while the FIFO is non-empty; i_push is accepted when not full or when a pop happens in the same cycle.
module stbus_fifo
  import stbus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk50,
  input  logic        reset_in_rg,
  input  logic        i_push,
  input  fifo_entry_t i_entry,
  input  logic        i_pop,
  output fifo_entry_t o_head,
  output logic        o_valid,
  output logic        o_full,
  output logic        o_empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  fifo_entry_t    r_mem [DEPTH];
  logic [CW-1:0]  r_count;
  logic           r_valid;
  logic           w_pop;
  logic           w_wr;
  logic [CW-1:0]  w_base;
  logic [CW-1:0]  w_count_nxt;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_pop       = i_pop & ~o_empty;
  assign w_wr        = i_push & (~o_full | w_pop);
  // Write slot is computed after the shift, so a pop moves it down by one.
  assign w_base      = w_pop ? (r_count - CW'(1)) : r_count;
  assign w_count_nxt = r_count + CW'(w_wr) - CW'(w_pop);

  always_ff @(posedge clk50) begin
    if (!reset_in_rg) begin
      r_count <= '0;
      r_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
        r_mem[DEPTH-1] <= '0;
      end
      if (w_wr) r_mem[w_base[AW-1:0]] <= i_entry;
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != '0);
    end
  end

  assign o_head  = r_mem[0];
  assign o_valid = r_valid;
endmodule

// File: rtl/stbus_deframer.sv
// ST-BUS serial receiver: synchronises c4/f0/data into clk50, tracks frame alignment,
// assembles slot bytes and queues enabled slots. out_valid/out_ready: pop when both high.
module stbus_deframer
  import stbus_pkg::*;
#(
  parameter logic [31:0] SLOT_MASK   = 32'hFFFF_FFFF,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk50,
  input  logic       reset_in_rg,
  input  logic       c4,
  input  logic       f0,
  input  logic       data_from_dt,
  output logic [7:0] out_data,
  output logic [4:0] out_slot,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       in_sync,
  output logic       frame_err,
  output logic       overflow,
  input  logic       err_clr,
  output logic       cpu_int,
  input  logic       int_ack
);
  localparam int CNT_W = $clog2(C4_PER_FRAME);

  logic [SYNC_STAGES-1:0]   r_c4_sync, r_f0_sync, r_dat_sync;
  logic                     r_c4_prev;
  state_t                   r_state;
  logic [CNT_W-1:0]         r_cnt;
  logic [BITS_PER_SLOT-1:0] r_shift;
  logic                     r_cmp;
  fifo_entry_t              r_cmp_entry;
  logic                     r_frame_err, r_overflow, r_cpu_int;

  logic        w_cur, w_fall, w_f0_s, w_data_s;
  logic        w_ferr_set, w_push, w_pop, w_ovf_set, w_int_set;
  logic        w_full, w_empty, w_valid;
  fifo_entry_t w_head;

  always_ff @(posedge clk50) begin
    if (!reset_in_rg) begin
      r_c4_sync  <= '0;
      r_f0_sync  <= '1;
      r_dat_sync <= '0;
      r_c4_prev  <= 1'b0;
    end else begin
      r_c4_sync  <= {r_c4_sync[SYNC_STAGES-2:0], c4};
      r_f0_sync  <= {r_f0_sync[SYNC_STAGES-2:0], f0};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], data_from_dt};
      r_c4_prev  <= w_cur;
    end
  end

  // f0 and data are taken from the same stage as the c4 edge so all three stay aligned.
  assign w_cur    = r_c4_sync[SYNC_STAGES-1];
  assign w_f0_s   = r_f0_sync[SYNC_STAGES-1];
  assign w_data_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall   = r_c4_prev & ~w_cur;

  always_ff @(posedge clk50) begin
    if (!reset_in_rg) begin
      r_state     <= HUNT;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_cmp       <= 1'b0;
      r_cmp_entry <= '0;
    end else begin
      r_cmp <= 1'b0;
      if (w_fall) begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (r_state == HUNT) begin
          if (!w_f0_s) begin
            r_cnt   <= CNT_W'(1);
            r_state <= SYNC;
          end
        end else if (!w_f0_s && (r_cnt != '0)) begin
          r_cnt   <= CNT_W'(1);
          r_shift <= '0;
        end else if (w_f0_s && (r_cnt == '0)) begin
          r_state <= HUNT;
          r_shift <= '0;
        end else if (r_cnt[0]) begin
          r_shift <= {r_shift[BITS_PER_SLOT-2:0], w_data_s};
          if (r_cnt[3:1] == 3'd7) begin
            r_cmp            <= 1'b1;
            r_cmp_entry.slot <= r_cnt[CNT_W-1:4];
            r_cmp_entry.data <= {r_shift[BITS_PER_SLOT-2:0], w_data_s};
          end
        end
      end
    end
  end

  assign w_ferr_set = w_fall & (r_state == SYNC) &
                      ((~w_f0_s & (r_cnt != '0)) | (w_f0_s & (r_cnt == '0)));
  assign w_push     = r_cmp & SLOT_MASK[r_cmp_entry.slot];
  assign w_pop      = out_ready & ~w_empty;
  assign w_ovf_set  = w_push & w_full & ~w_pop;
  assign w_int_set  = r_cmp & (r_cmp_entry.slot == 5'(SLOTS - 1));

  // Sticky flags: a set in the same cycle as its clear takes priority.
  always_ff @(posedge clk50) begin
    if (!reset_in_rg) begin
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_cpu_int   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr_set | (r_frame_err & ~err_clr);
      r_overflow  <= w_ovf_set  | (r_overflow  & ~err_clr);
      r_cpu_int   <= w_int_set  | (r_cpu_int   & ~int_ack);
    end
  end

  stbus_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk50       (clk50),
    .reset_in_rg (reset_in_rg),
    .i_push      (w_push),
    .i_entry     (r_cmp_entry),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_valid),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign out_data  = w_head.data;
  assign out_slot  = w_head.slot;
  assign out_valid = w_valid;
  assign in_sync   = (r_state == SYNC);
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
  assign cpu_int   = r_cpu_int;
endmodule

// File: tb/tb_stbus_deframer.sv
// Directed bench for stbus_deframer: default instance plus a SLOT_MASK=5 instance on shared inputs.
// c4 runs at 4 clk50 cycles per period; inputs change on the falling clk50 edge.
module tb_stbus_deframer;
  logic clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  logic       reset_in_rg, c4, f0, data_from_dt, out_ready, m_out_ready, err_clr, int_ack;
  logic [7:0] out_data, m_out_data;
  logic [4:0] out_slot, m_out_slot;
  logic       out_valid, in_sync, frame_err, overflow, cpu_int;
  logic       m_out_valid, m_in_sync, m_frame_err, m_overflow, m_cpu_int;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  frame_bytes [32];
  logic [12:0] exp_q[$];
  logic [12:0] got_q[$];
  logic [12:0] m_got_q[$];

  stbus_deframer dut (
    .clk50(clk50), .reset_in_rg(reset_in_rg), .c4(c4), .f0(f0), .data_from_dt(data_from_dt),
    .out_data(out_data), .out_slot(out_slot), .out_valid(out_valid), .out_ready(out_ready),
    .in_sync(in_sync), .frame_err(frame_err), .overflow(overflow), .err_clr(err_clr),
    .cpu_int(cpu_int), .int_ack(int_ack)
  );

  stbus_deframer #(.SLOT_MASK(32'h0000_0005)) dut_m (
    .clk50(clk50), .reset_in_rg(reset_in_rg), .c4(c4), .f0(f0), .data_from_dt(data_from_dt),
    .out_data(m_out_data), .out_slot(m_out_slot), .out_valid(m_out_valid), .out_ready(m_out_ready),
    .in_sync(m_in_sync), .frame_err(m_frame_err), .overflow(m_overflow), .err_clr(err_clr),
    .cpu_int(m_cpu_int), .int_ack(int_ack)
  );

  // Records every accepted head, sampled mid low-phase of clk50.
  always @(negedge clk50) begin
    #2;
    if (out_valid && out_ready) got_q.push_back({out_slot, out_data});
    if (m_out_valid && m_out_ready) m_got_q.push_back({m_out_slot, m_out_data});
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk50);
  endtask

  function automatic logic bit_of(input int k);
    logic [7:0] byt;
    if (k % 2 == 0) return 1'b0;
    byt = frame_bytes[k / 16];
    return byt[7 - ((k / 2) % 8)];
  endfunction

  // One c4 period; returns two clk50 cycles after c4 falls.
  task automatic c4_event(input logic f0v, input logic dv);
    c4 = 1'b1; f0 = f0v; data_from_dt = dv;
    wait_cycles(2);
    c4 = 1'b0;
    wait_cycles(2);
  endtask

  task automatic send_events(input int k0, input int k1, input int f0k);
    for (int k = k0; k <= k1; k++) c4_event((k == f0k) ? 1'b0 : 1'b1, bit_of(k));
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; wait_cycles(1); err_clr = 1'b0;
  endtask

  task automatic pulse_int_ack();
    int_ack = 1'b1; wait_cycles(1); int_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset_in_rg = 1'b0; c4 = 1'b0; f0 = 1'b1; data_from_dt = 1'b0;
    out_ready = 1'b1; m_out_ready = 1'b1; err_clr = 1'b0; int_ack = 1'b0;
    wait_cycles(4);
    checks++;
    if ({out_data, out_slot, out_valid, in_sync, frame_err, overflow, cpu_int} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {out_data, out_slot, out_valid, in_sync, frame_err, overflow, cpu_int});
    end
    reset_in_rg = 1'b1;
    wait_cycles(3);
    checks++;
    if ({out_valid, in_sync} !== 2'b00) begin
      failures++; $display("FAIL reset_release got=%b exp=00", {out_valid, in_sync});
    end
  endtask

  task automatic test_normal_frame();
    for (int n = 0; n < 32; n++) frame_bytes[n] = 8'hA0 + 8'(n);
    got_q.delete(); exp_q.delete();
    send_events(0, 511, 0);
    wait_cycles(8);
    for (int n = 0; n < 32; n++) exp_q.push_back({5'(n), frame_bytes[n]});
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL normal_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL normal_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({cpu_int, in_sync, frame_err, overflow} !== 4'b1100) begin
      failures++;
      $display("FAIL normal_flags got=%b exp=1100", {cpu_int, in_sync, frame_err, overflow});
    end
    pulse_int_ack();
    wait_cycles(1);
    checks++;
    if (cpu_int !== 1'b0) begin failures++; $display("FAIL int_ack_clear got=%b exp=0", cpu_int); end
  endtask

  task automatic test_slot_mask();
    for (int n = 0; n < 32; n++) frame_bytes[n] = 8'h10 + 8'(n * 3);
    got_q.delete(); m_got_q.delete(); exp_q.delete();
    send_events(0, 511, 0);
    wait_cycles(8);
    exp_q.push_back({5'd0, frame_bytes[0]});
    exp_q.push_back({5'd2, frame_bytes[2]});
    checks++;
    if (m_got_q.size() != 2) begin
      failures++; $display("FAIL mask_count got=%0d exp=2", m_got_q.size());
    end
    foreach (exp_q[i]) if (i < m_got_q.size()) begin
      checks++;
      if (m_got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL mask_entry%0d got=%h exp=%h", i, m_got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (m_cpu_int !== 1'b1) begin failures++; $display("FAIL mask_cpu_int got=%b exp=1", m_cpu_int); end
    checks++;
    if (got_q.size() != 32) begin
      failures++; $display("FAIL unmasked_count got=%0d exp=32", got_q.size());
    end
    pulse_int_ack();
  endtask

  task automatic test_back_pressure();
    for (int n = 0; n < 32; n++) frame_bytes[n] = 8'h5A ^ 8'(n);
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    send_events(0, 511, 0);
    wait_cycles(8);
    checks++;
    if ({out_valid, out_slot, out_data, overflow} !== {1'b1, 5'd0, frame_bytes[0], 1'b1}) begin
      failures++;
      $display("FAIL bp_hold got=%h exp=%h", {out_valid, out_slot, out_data, overflow},
               {1'b1, 5'd0, frame_bytes[0], 1'b1});
    end
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL bp_no_pop got=%0d exp=0", got_q.size()); end
    pulse_err_clr();
    wait_cycles(1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL bp_err_clr got=%b exp=0", overflow); end
    out_ready = 1'b1;
    wait_cycles(8);
    for (int n = 0; n < 4; n++) exp_q.push_back({5'(n), frame_bytes[n]});
    checks++;
    if (got_q.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL bp_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    pulse_int_ack();
  endtask

  task automatic test_frame_pulse();
    for (int n = 0; n < 32; n++) frame_bytes[n] = 8'hC0 + 8'(n);
    got_q.delete(); exp_q.delete();
    send_events(0, 199, 0);
    send_events(0, 511, 0);
    wait_cycles(8);
    for (int n = 0; n < 12; n++) exp_q.push_back({5'(n), frame_bytes[n]});
    for (int n = 0; n < 32; n++) exp_q.push_back({5'(n), frame_bytes[n]});
    checks++;
    if ({frame_err, in_sync} !== 2'b11) begin
      failures++; $display("FAIL early_f0 got=%b exp=11", {frame_err, in_sync});
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL realign_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL realign_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    pulse_err_clr();
    wait_cycles(1);
    checks++;
    if (frame_err !== 1'b0) begin failures++; $display("FAIL ferr_clear got=%b exp=0", frame_err); end
    send_events(0, 0, -1);
    wait_cycles(4);
    checks++;
    if ({frame_err, in_sync} !== 2'b10) begin
      failures++; $display("FAIL missing_f0 got=%b exp=10", {frame_err, in_sync});
    end
    pulse_err_clr();
    pulse_int_ack();
  endtask

  task automatic test_collisions();
    for (int n = 0; n < 32; n++) frame_bytes[n] = 8'h70 + 8'(n);
    got_q.delete(); exp_q.delete();
    out_ready = 1'b0;
    send_events(0, 79, 0);
    wait_cycles(4);
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
    pulse_err_clr();
    wait_cycles(1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    // err_clr lands on the clk50 edge where slot 5 is dropped.
    send_events(80, 94, -1);
    c4_event(1'b1, bit_of(95));
    wait_cycles(1);
    err_clr = 1'b1;
    wait_cycles(1);
    err_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_vs_clr got=%b exp=1", overflow); end
    pulse_err_clr();
    // Pop begins on the same edge that pushes slot 6 into the full FIFO.
    send_events(96, 110, -1);
    c4_event(1'b1, bit_of(111));
    wait_cycles(1);
    out_ready = 1'b1;
    wait_cycles(1);
    checks++;
    if (overflow !== 1'b0) begin failures++; $display("FAIL full_push_pop got=%b exp=0", overflow); end
    send_events(112, 510, -1);
    c4_event(1'b1, bit_of(511));
    wait_cycles(1);
    int_ack = 1'b1;
    wait_cycles(1);
    int_ack = 1'b0;
    checks++;
    if (cpu_int !== 1'b1) begin failures++; $display("FAIL int_vs_ack got=%b exp=1", cpu_int); end
    wait_cycles(8);
    for (int n = 0; n < 4; n++) exp_q.push_back({5'(n), frame_bytes[n]});
    for (int n = 6; n < 32; n++) exp_q.push_back({5'(n), frame_bytes[n]});
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL coll_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL coll_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    for (int n = 0; n < 32; n++) frame_bytes[n] = 8'h30 + 8'(n);
    got_q.delete(); exp_q.delete();
    out_ready = 1'b1;
    send_events(0, 169, 0);
    checks++;
    if ({in_sync, cpu_int} !== 2'b11) begin
      failures++; $display("FAIL pre_reset got=%b exp=11", {in_sync, cpu_int});
    end
    reset_in_rg = 1'b0;
    wait_cycles(1);
    checks++;
    if ({out_data, out_slot, out_valid, in_sync, frame_err, overflow, cpu_int} !== 19'd0) begin
      failures++;
      $display("FAIL midreset_outputs got=%h exp=0",
               {out_data, out_slot, out_valid, in_sync, frame_err, overflow, cpu_int});
    end
    wait_cycles(2);
    reset_in_rg = 1'b1;
    wait_cycles(2);
    for (int n = 0; n < 10; n++) exp_q.push_back({5'(n), frame_bytes[n]});
    checks++;
    if (got_q.size() != 10) begin failures++; $display("FAIL prereset_count got=%0d exp=10", got_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL prereset_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
    got_q.delete(); exp_q.delete();
    send_events(170, 233, -1);
    wait_cycles(8);
    checks++;
    if ({got_q.size() != 0, in_sync} !== 2'b00) begin
      failures++; $display("FAIL hunt_after_reset got=%0d/%b exp=0/0", got_q.size(), in_sync);
    end
    send_events(0, 47, 0);
    wait_cycles(8);
    for (int n = 0; n < 3; n++) exp_q.push_back({5'(n), frame_bytes[n]});
    checks++;
    if ({got_q.size() == 3, in_sync} !== 2'b11) begin
      failures++; $display("FAIL resume_after_f0 got=%0d/%b exp=3/1", got_q.size(), in_sync);
    end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL resume_entry%0d got=%h exp=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal_frame();
    test_slot_mask();
    test_back_pressure();
    test_frame_pulse();
    test_collisions();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
